local_event_fifo: RTL and testbench
===================================

Name: local_event_fifo

Overview:
- Per-channel event buffer between the channel controller and the event router.
- Captures each completed event word the channel controller produces (write strobe) and holds it until the router pops it.
- The router pops with the active-low read_local_fifo_n.
- Provides first-word-fall-through output, occupancy flags, an occupancy count for FIFO diagnostics, and a sticky overflow indicator.

Parameters:
- WIDTH, 64: packet width; stored event word is WIDTH-1 bits (parity bit added downstream).
- DEPTH, 4: number of event entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counter.

Ports:
- clk  input  1  master clock.
- reset_n  input  1  asynchronous digital reset, active low.
- event_in  input  WIDTH-1  event word from channel controller.
- write_n  input  1  low for one cycle to push event_in.
- read_local_fifo_n  input  1  low to pop head entry (from event router).
- event_out  output  WIDTH-1  head entry, first-word-fall-through.
- fifo_empty  output  1  high when no entries held.
- fifo_full  output  1  high when DEPTH entries held.
- fifo_half  output  1  high when count >= DEPTH/2.
- fifo_counter  output  CNT_W  current occupancy, 0..DEPTH.
- fifo_overflow  output  1  sticky; set when a push is dropped.
- clear_overflow  input  1  high for one cycle clears fifo_overflow.

Behaviour:
- Single clock domain, all state on posedge clk; asynchronous clear on negedge reset_n.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, fifo_counter = 0.
  - fifo_empty = 1, fifo_full = 0, fifo_half = 0, fifo_overflow = 0.
  - event_out = 0.
  - Storage array is not reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally; no special wrap logic.
- Push accepted when write_n = 0 and not full:
  - mem[wr_ptr] <= event_in, wr_ptr++.
  - Entry is visible on event_out the cycle after the push edge if the FIFO was empty.
- Pop accepted when read_local_fifo_n = 0 and not empty:
  - rd_ptr++.
  - event_out shows the next entry (or 0 if now empty) after the edge.
- event_out = mem[rd_ptr] when not empty, else all zeros. Combinational from registered state, so no data latency beyond one edge after the push.
- fifo_counter:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Flags are derived from fifo_counter and are registered-equivalent (change only on clock edges):
  - fifo_empty = (count == 0)
  - fifo_full = (count == DEPTH)
  - fifo_half = (count >= DEPTH/2)
- Boundary rules:
  - Push while full and no pop: word dropped, storage/pointers unchanged, fifo_overflow <= 1.
  - Push while full with simultaneous pop: both accepted. Head popped, new word written to the freed slot. Count stays DEPTH, no overflow.
  - Pop while empty: ignored; pointers and count unchanged. Simultaneous push while empty is accepted; no bypass to event_out in the same cycle.
  - clear_overflow and an overflowing push in the same cycle: set wins, fifo_overflow = 1.
  - Reset mid-operation: all contents discarded, outputs return to reset values immediately (asynchronous).
- Push and pop are level-sampled each cycle; a strobe held low N cycles performs N operations, subject to the rules above.
- No state machine beyond pointer/count registers; the overflow bit is a 2-state sticky flag (CLEAR -> SET on dropped push, SET -> CLEAR on clear_overflow without a concurrent drop).

Test Plan:
- Reset then idle 5 cycles -> fifo_empty = 1, fifo_counter = 0, event_out = 0, fifo_overflow = 0.
- Push 63'h1234 once, then pop after 3 cycles:
  - event_out = 63'h1234 from the cycle after the push.
  - fifo_counter = 1, fifo_half = 0.
  - After pop: fifo_empty = 1, event_out = 0.
- Push 0xA1,0xA2,0xA3,0xA4 back-to-back (DEPTH = 4):
  - fifo_half rises after the 2nd push; fifo_full = 1 after the 4th; fifo_counter = 4.
  - Pop 4 times -> event_out sequence A1,A2,A3,A4, then empty.
- Fill to 4, push 0xB5 with no pop:
  - fifo_overflow = 1, fifo_counter = 4, pops return A1..A4 (B5 absent).
  - Pulse clear_overflow -> fifo_overflow = 0.
- Fill to 4, push 0xC5 with simultaneous pop:
  - No overflow, counter stays 4.
  - Subsequent pops return A2,A3,A4,C5, checking pointer wrap.
- Push 2 words, assert reset_n = 0 mid-cycle for 1 cycle:
  - Outputs return to reset values asynchronously.
  - Pop afterwards is ignored; fifo_empty stays 1.

Source files
------------

// File: rtl/local_event_fifo.sv
// ---------------------------------------------------------------------------
// local_event_fifo
//   Per-channel event buffer between the channel controller and the event
//   router. Completed event words are pushed with an active-low write strobe
//   and held until the router pops them with an active-low read strobe.
//   The head entry is presented first-word-fall-through.
//
// Ports
//   clk                master clock
//   reset_n            asynchronous reset, active low
//   event_in           event word from channel controller (WIDTH-1 bits)
//   write_n            low to push event_in (one push per cycle held low)
//   read_local_fifo_n  low to pop the head entry (one pop per cycle held low)
//   event_out          head entry when not empty, else zero
//   fifo_empty         no entries held
//   fifo_full          DEPTH entries held
//   fifo_half          occupancy >= DEPTH/2
//   fifo_counter       occupancy 0..DEPTH
//   fifo_overflow      sticky, set when a push is dropped on a full FIFO
//   clear_overflow     one-cycle pulse clears fifo_overflow (a drop wins)
// ---------------------------------------------------------------------------
module local_event_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-2:0] event_in,
    input  logic             write_n,
    input  logic             read_local_fifo_n,
    output logic [WIDTH-2:0] event_out,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             fifo_half,
    output logic [CNT_W-1:0] fifo_counter,
    output logic             fifo_overflow,
    input  logic             clear_overflow
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(DEPTH / 2);

    typedef enum logic {
        OVF_CLEAR = 1'b0,
        OVF_SET   = 1'b1
    } ovf_state_e;

    // Storage is intentionally not reset; event_out masks it while empty.
    logic [WIDTH-2:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    ovf_state_e       ovf_q,    ovf_d;

    logic empty, full;
    logic push_ok, pop_ok, push_drop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_C);

    // A pop on a full FIFO frees the slot the concurrent push lands in, so a
    // full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok    = !read_local_fifo_n && !empty;
    assign push_ok   = !write_n && (!full || pop_ok);
    assign push_drop = !write_n && full && !pop_ok;

    // ---------------------------------------------------------------------
    // Pointer / occupancy next state
    // ---------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= event_in;
    end

    // ---------------------------------------------------------------------
    // Sticky overflow flag: a dropped push beats a concurrent clear.
    // ---------------------------------------------------------------------
    always_comb begin
        ovf_d = ovf_q;
        unique case (ovf_q)
            OVF_CLEAR: if (push_drop)                        ovf_d = OVF_SET;
            OVF_SET:   if (clear_overflow && !push_drop)     ovf_d = OVF_CLEAR;
            default:   ovf_d = OVF_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovf_q <= OVF_CLEAR;
        else          ovf_q <= ovf_d;
    end

    // ---------------------------------------------------------------------
    // Outputs: all decoded from registered state, so they move only on
    // clock edges (or asynchronously on reset).
    // ---------------------------------------------------------------------
    assign event_out     = empty ? '0 : mem[rd_ptr_q];
    assign fifo_empty    = empty;
    assign fifo_full     = full;
    assign fifo_half     = (cnt_q >= HALF_C);
    assign fifo_counter  = cnt_q;
    assign fifo_overflow = (ovf_q == OVF_SET);

endmodule

// File: tb/tb_local_event_fifo.sv
module tb_local_event_fifo;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-2:0] event_in = '0;
    logic             write_n = 1'b1;
    logic             read_local_fifo_n = 1'b1;
    logic             clear_overflow = 1'b0;
    logic [WIDTH-2:0] event_out;
    logic             fifo_empty, fifo_full, fifo_half, fifo_overflow;
    logic [CNT_W-1:0] fifo_counter;

    int checks = 0;
    int fails  = 0;

    // Reference model: a plain queue of words plus a sticky flag.
    logic [WIDTH-2:0] mq[$];
    bit               m_ovf = 0;

    local_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .event_in(event_in), .write_n(write_n),
        .read_local_fifo_n(read_local_fifo_n), .event_out(event_out),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_half(fifo_half),
        .fifo_counter(fifo_counter), .fifo_overflow(fifo_overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    // One clock edge: the model consumes the inputs seen at the edge, then
    // time advances 1 unit so outputs are sampled away from the edge.
    task automatic tick();
        bit do_pop, do_push, drop;
        @(posedge clk);
        if (!reset_n) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            do_pop  = !read_local_fifo_n && mq.size() > 0;
            do_push = !write_n && (mq.size() < DEPTH || do_pop);
            drop    = !write_n && mq.size() == DEPTH && !do_pop;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(event_in);
            if (drop)              m_ovf = 1;
            else if (clear_overflow) m_ovf = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        write_n = 1'b1; read_local_fifo_n = 1'b1; clear_overflow = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-2:0] d);
        event_in = d; write_n = 1'b0; tick(); write_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; idle_inputs();
        tick(); tick();
        reset_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (fifo_empty !== 1'b1 || fifo_counter !== '0 || event_out !== '0 ||
            fifo_overflow !== 1'b0 || fifo_full !== 1'b0 || fifo_half !== 1'b0) begin
            fails++;
            $display("FAIL reset: empty=%b cnt=%0d out=%h ovf=%b full=%b half=%b expected 1 0 0 0 0 0",
                     fifo_empty, fifo_counter, event_out, fifo_overflow, fifo_full, fifo_half);
        end
    endtask

    task automatic test_single();
        logic [WIDTH-2:0] w;
        w = 63'h1234;
        push(w);
        checks++;
        if (event_out !== w || fifo_counter !== CNT_W'(1) || fifo_half !== 1'b0 || fifo_empty !== 1'b0) begin
            fails++;
            $display("FAIL single_push: out=%h cnt=%0d half=%b empty=%b expected %h 1 0 0",
                     event_out, fifo_counter, fifo_half, fifo_empty, w);
        end
        repeat (3) tick();
        read_local_fifo_n = 1'b0; tick(); read_local_fifo_n = 1'b1;
        checks++;
        if (fifo_empty !== 1'b1 || event_out !== '0 || fifo_counter !== '0) begin
            fails++;
            $display("FAIL single_pop: empty=%b out=%h cnt=%0d expected 1 0 0",
                     fifo_empty, event_out, fifo_counter);
        end
    endtask

    task automatic fill_a();
        for (int i = 0; i < DEPTH; i++) begin
            push(63'hA1 + 63'(i));
            checks++;
            if (fifo_half !== (i >= 1) || fifo_full !== (i == DEPTH - 1) ||
                fifo_counter !== CNT_W'(i + 1)) begin
                fails++;
                $display("FAIL fill_%0d: half=%b full=%b cnt=%0d expected %b %b %0d",
                         i, fifo_half, fifo_full, fifo_counter, i >= 1, i == DEPTH - 1, i + 1);
            end
        end
    endtask

    task automatic drain_expect(input logic [WIDTH-2:0] exp[DEPTH], input string nm);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (event_out !== exp[i]) begin
                fails++;
                $display("FAIL %s_pop%0d: out=%h expected %h", nm, i, event_out, exp[i]);
            end
            read_local_fifo_n = 1'b0; tick(); read_local_fifo_n = 1'b1;
        end
        checks++;
        if (fifo_empty !== 1'b1 || event_out !== '0) begin
            fails++;
            $display("FAIL %s_empty: empty=%b out=%h expected 1 0", nm, fifo_empty, event_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-2:0] e[DEPTH];
        fill_a();
        for (int i = 0; i < DEPTH; i++) e[i] = 63'hA1 + 63'(i);
        drain_expect(e, "b2b");
    endtask

    task automatic test_overflow();
        logic [WIDTH-2:0] e[DEPTH];
        fill_a();
        push(63'hB5);
        checks++;
        if (fifo_overflow !== 1'b1 || fifo_counter !== CNT_W'(DEPTH)) begin
            fails++;
            $display("FAIL overflow_set: ovf=%b cnt=%0d expected 1 %0d", fifo_overflow, fifo_counter, DEPTH);
        end
        // clear and drop in the same cycle: set must win
        event_in = 63'hB6; write_n = 1'b0; clear_overflow = 1'b1; tick(); idle_inputs();
        checks++;
        if (fifo_overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_set_wins: ovf=%b expected 1", fifo_overflow);
        end
        for (int i = 0; i < DEPTH; i++) e[i] = 63'hA1 + 63'(i);
        drain_expect(e, "ovf");
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        checks++;
        if (fifo_overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_clear: ovf=%b expected 0", fifo_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-2:0] e[DEPTH];
        fill_a();
        event_in = 63'hC5; write_n = 1'b0; read_local_fifo_n = 1'b0; tick(); idle_inputs();
        checks++;
        if (fifo_overflow !== 1'b0 || fifo_counter !== CNT_W'(DEPTH) || fifo_full !== 1'b1) begin
            fails++;
            $display("FAIL full_push_pop: ovf=%b cnt=%0d full=%b expected 0 %0d 1",
                     fifo_overflow, fifo_counter, fifo_full, DEPTH);
        end
        e[0] = 63'hA2; e[1] = 63'hA3; e[2] = 63'hA4; e[3] = 63'hC5;
        drain_expect(e, "wrap");
    endtask

    task automatic test_empty_pop_push();
        // pop on empty is ignored, the concurrent push is accepted, no bypass
        event_in = 63'h7E57; write_n = 1'b0; read_local_fifo_n = 1'b0; tick(); idle_inputs();
        checks++;
        if (fifo_counter !== CNT_W'(1) || event_out !== 63'h7E57) begin
            fails++;
            $display("FAIL empty_pop_push: cnt=%0d out=%h expected 1 7e57", fifo_counter, event_out);
        end
        read_local_fifo_n = 1'b0; tick(); tick(); read_local_fifo_n = 1'b1;
        checks++;
        if (fifo_counter !== '0 || fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL empty_pop_ignored: cnt=%0d empty=%b expected 0 1", fifo_counter, fifo_empty);
        end
    endtask

    task automatic test_reset_mid();
        push(63'h11); push(63'h22);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (fifo_empty !== 1'b1 || fifo_counter !== '0 || event_out !== '0 ||
            fifo_half !== 1'b0 || fifo_full !== 1'b0 || fifo_overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: empty=%b cnt=%0d out=%h half=%b full=%b ovf=%b expected 1 0 0 0 0 0",
                     fifo_empty, fifo_counter, event_out, fifo_half, fifo_full, fifo_overflow);
        end
        tick();
        reset_n = 1'b1;
        read_local_fifo_n = 1'b0; tick(); read_local_fifo_n = 1'b1;
        checks++;
        if (fifo_empty !== 1'b1 || fifo_counter !== '0 || event_out !== '0) begin
            fails++;
            $display("FAIL reset_pop_ignored: empty=%b cnt=%0d out=%h expected 1 0 0",
                     fifo_empty, fifo_counter, event_out);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-2:0] exp_out;
        int bias;
        for (int c = 0; c < 600; c++) begin
            // alternate phases biased toward filling and draining
            bias = ((c / 50) % 2 == 0) ? 3 : 1;
            write_n           = !($urandom_range(0, 3) < bias);
            read_local_fifo_n = !($urandom_range(0, 3) < 4 - bias);
            clear_overflow    = ($urandom_range(0, 15) == 0);
            event_in          = {$urandom(), $urandom()} >> 1;
            tick();
            exp_out = (mq.size() > 0) ? mq[0] : '0;
            checks++;
            if (event_out !== exp_out || fifo_counter !== CNT_W'(mq.size()) ||
                fifo_empty !== (mq.size() == 0) || fifo_full !== (mq.size() == DEPTH) ||
                fifo_half !== (mq.size() >= DEPTH / 2) || fifo_overflow !== m_ovf) begin
                fails++;
                $display("FAIL random_c%0d: out=%h cnt=%0d e/f/h/o=%b%b%b%b expected %h %0d %b%b%b%b",
                         c, event_out, fifo_counter, fifo_empty, fifo_full, fifo_half, fifo_overflow,
                         exp_out, mq.size(), mq.size() == 0, mq.size() == DEPTH,
                         mq.size() >= DEPTH / 2, m_ovf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_empty_pop_push();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
